// File: rtl/feistel_state_reg_pkg.sv
// Shared definitions for the Feistel round engine: FSM states and default geometry,
// reused by the key schedule and the top level.
package feistel_state_reg_pkg;

    localparam int DEF_HALF_W = 32;
    localparam int DEF_ROUNDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/feistel_round_ctr.sv
// Up/down subkey index counter. It saturates on the last round so that ROUND_IDX
// keeps pointing at the final subkey instead of wrapping.
module feistel_round_ctr
    import feistel_state_reg_pkg::*;
#(
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             load_down,
    input  logic             step,
    input  logic             down,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam logic [IDX_W-1:0] TOP = IDX_W'(ROUNDS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (load) begin
            idx <= load_down ? TOP : '0;
        end else if (step && !last) begin
            idx <= down ? idx - 1'b1 : idx + 1'b1;
        end
    end

    // down follows the mode latched at accept, so a live DECRYPT change cannot move it
    assign last = down ? (idx == '0) : (idx == TOP);

endmodule

// File: rtl/feistel_state_reg.sv
// Feistel L/R state register with an external f-function: one round per clock,
// valid/ready on both sides, final half swap on the output word.
module feistel_state_reg
    import feistel_state_reg_pkg::*;
#(
    parameter int HALF_W = DEF_HALF_W,
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLR,
    input  logic                DECRYPT,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [2*HALF_W-1:0] DATA_IN,
    output logic [HALF_W-1:0]   RIGHT_OUT,
    input  logic [HALF_W-1:0]   F_IN,
    output logic [IDX_W-1:0]    ROUND_IDX,
    output logic                BUSY,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [2*HALF_W-1:0] DATA_OUT
);

    state_t              state;
    logic [HALF_W-1:0]   l;
    logic [HALF_W-1:0]   r;
    logic                mode;
    logic                in_ready_q;
    logic                busy_q;
    logic                out_valid_q;
    logic                accept;
    logic                last;

    assign accept = IN_VALID & in_ready_q;

    feistel_round_ctr #(
        .ROUNDS (ROUNDS),
        .IDX_W  (IDX_W)
    ) u_ctr (
        .clk       (CLK),
        .rst       (RST),
        .clr       (CLR),
        .load      (accept),
        .load_down (DECRYPT),
        .step      (busy_q),
        .down      (mode),
        .idx       (ROUND_IDX),
        .last      (last)
    );

    // Handshake flags are registered next to the state so they change only on edges
    // (or immediately on RST) and never glitch with the inputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            l           <= '0;
            r           <= '0;
            mode        <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (CLR) begin
            state       <= IDLE;
            l           <= '0;
            r           <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        l          <= DATA_IN[2*HALF_W-1:HALF_W];
                        r          <= DATA_IN[HALF_W-1:0];
                        mode       <= DECRYPT;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    l <= r;
                    r <= l ^ F_IN;
                    if (last) begin
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign BUSY      = busy_q;
    assign OUT_VALID = out_valid_q;
    assign RIGHT_OUT = r;
    // Output word is gated so nothing leaks onto the bus between blocks.
    assign DATA_OUT  = out_valid_q ? {r, l} : '0;

endmodule

// File: tb/tb_feistel_state_reg.sv
// Directed bench for feistel_state_reg: transaction-level model plus per-cycle compare,
// with literal results pinning the model.
module tb_feistel_state_reg;

    localparam int HW = 32;
    localparam int NR = 16;
    localparam int IW = $clog2(NR);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          decrypt = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [63:0]   data_in = '0;
    logic [HW-1:0] f_in;
    logic          in_ready, busy, out_valid;
    logic [HW-1:0] right_out;
    logic [IW-1:0] round_idx;
    logic [63:0]   data_out;

    logic          dec3 = 1'b0;
    logic          in_valid3 = 1'b0;
    logic          out_ready3 = 1'b0;
    logic [63:0]   data_in3 = '0;
    logic [31:0]   f_in3 = 32'hFFFF_FFFF;
    logic          in_ready3, busy3, out_valid3;
    logic [31:0]   right_out3;
    logic [1:0]    round_idx3;
    logic [63:0]   data_out3;

    int checks = 0;
    int errors = 0;
    int fsel = 0;
    logic [IW-1:0] idx_seq[$];

    always #5 clk = ~clk;

    feistel_state_reg dut (
        .CLK(clk), .RST(rst), .CLR(clr), .DECRYPT(decrypt), .IN_VALID(in_valid),
        .IN_READY(in_ready), .DATA_IN(data_in), .RIGHT_OUT(right_out), .F_IN(f_in),
        .ROUND_IDX(round_idx), .BUSY(busy), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .DATA_OUT(data_out)
    );

    feistel_state_reg #(.HALF_W(32), .ROUNDS(3)) dut3 (
        .CLK(clk), .RST(rst), .CLR(clr), .DECRYPT(dec3), .IN_VALID(in_valid3),
        .IN_READY(in_ready3), .DATA_IN(data_in3), .RIGHT_OUT(right_out3), .F_IN(f_in3),
        .ROUND_IDX(round_idx3), .BUSY(busy3), .OUT_VALID(out_valid3), .OUT_READY(out_ready3),
        .DATA_OUT(data_out3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] f_fn(input int sel, input logic [31:0] r, input logic [IW-1:0] k);
        case (sel)
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return {r[28:0], r[31:29]} ^ (32'h9E37_79B9 * (32'(k) + 32'd1));
        endcase
    endfunction

    // {L,R} after n rounds, keys taken in schedule order for the mode
    function automatic logic [63:0] run_rounds(input logic [63:0] blk, input logic dec,
                                               input int n, input int sel);
        logic [31:0] l, r, t;
        l = blk[63:32];
        r = blk[31:0];
        for (int i = 0; i < n; i++) begin
            t = l ^ f_fn(sel, r, IW'(dec ? NR - 1 - i : i));
            l = r;
            r = t;
        end
        return {l, r};
    endfunction

    function automatic logic [63:0] swap(input logic [63:0] x);
        return {x[31:0], x[63:32]};
    endfunction

    assign f_in = f_fn(fsel, right_out, round_idx);

    // Transaction model: 0 idle, 1 running (m_k rounds done), 2 holding result
    int            m_phase = 0;
    int            m_k = 0;
    int            m_sel = 0;
    int            cyc = 0;
    int            m_acc = 0;
    logic          m_dec = 1'b0;
    logic [63:0]   m_blk = '0;
    logic [63:0]   m_lr = '0;
    logic [IW-1:0] m_idx = '0;
    logic          ov_prev = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_lr    <= '0;
            m_idx   <= '0;
            m_dec   <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (clr) begin
                m_phase <= 0;
                m_lr    <= '0;
                m_idx   <= '0;
            end else if (m_phase == 0) begin
                if (in_valid) begin
                    m_phase <= 1;
                    m_k     <= 0;
                    m_blk   <= data_in;
                    m_dec   <= decrypt;
                    m_sel   <= fsel;
                    m_lr    <= data_in;
                    m_idx   <= decrypt ? IW'(NR - 1) : '0;
                    m_acc   <= cyc;
                end
            end else if (m_phase == 1) begin
                m_k  <= m_k + 1;
                m_lr <= run_rounds(m_blk, m_dec, m_k + 1, m_sel);
                if (m_k + 1 == NR) m_phase <= 2;
                else m_idx <= m_dec ? IW'(NR - 2 - m_k) : IW'(m_k + 1);
            end else if (out_ready) begin
                m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_phase == 0);
        chk("busy", busy, m_phase == 1);
        chk("out_valid", out_valid, m_phase == 2);
        chk("data_out", data_out, (m_phase == 2) ? swap(m_lr) : 64'h0);
        chk("right_out", right_out, m_lr[31:0]);
        chk("round_idx", round_idx, m_idx);
        // edges counted from the accept edge inclusive
        if (out_valid && !ov_prev) chk("latency", cyc - m_acc, NR + 1);
        ov_prev <= out_valid;
    end

    task automatic run_block(input logic [63:0] blk, input logic dec, input bit toggle,
                             output logic [63:0] res);
        idx_seq.delete();
        res = '0;
        @(negedge clk);
        in_valid = 1'b1; data_in = blk; decrypt = dec; out_ready = 1'b1;
        @(posedge clk); #2 in_valid = 1'b0;
        for (int n = 0; n < NR + 10; n++) begin
            @(negedge clk);
            if (busy) idx_seq.push_back(round_idx);
            if (toggle && idx_seq.size() == 5) decrypt = ~dec;
            if (out_valid) begin
                res = data_out;
                break;
            end
        end
        chk("block_done", out_valid, 1);
    endtask

    task automatic wait_valid(input string name);
        for (int n = 0; n < NR + 10 && !out_valid; n++) @(negedge clk);
        chk(name, out_valid, 1);
    endtask

    task automatic check_idx(input logic dec);
        chk("idx_len", idx_seq.size(), NR);
        foreach (idx_seq[i]) chk("idx_seq", idx_seq[i], dec ? NR - 1 - i : i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] blk, res, enc, d0, res_a, res_b;
        int n;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_right_out", right_out, 0);
        #1 rst = 1'b0;

        // model pinned against hand-computed results
        chk("model_identity", swap(run_rounds(64'h0123_4567_89AB_CDEF, 1'b0, NR, 0)),
            64'h89AB_CDEF_0123_4567);

        fsel = 0;
        run_block(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, res);
        chk("identity_out", res, 64'h89AB_CDEF_0123_4567);
        check_idx(1'b0);

        fsel = 2;
        blk = 64'hDEAD_BEEF_CAFE_F00D;
        run_block(blk, 1'b0, 1'b0, enc);
        chk("mix_encrypt", enc, swap(run_rounds(blk, 1'b0, NR, 2)));
        check_idx(1'b0);

        // decrypting the ciphertext must restore the plaintext despite a mid-block mode toggle
        run_block(enc, 1'b1, 1'b1, res);
        chk("decrypt_roundtrip", res, blk);
        check_idx(1'b1);

        blk = 64'h1111_2222_3333_4444;
        @(negedge clk);
        in_valid = 1'b1; data_in = blk; decrypt = 1'b0; out_ready = 1'b0;
        @(posedge clk); #2 in_valid = 1'b0;
        wait_valid("bp_reached");
        d0 = data_out;
        chk("bp_data", d0, swap(run_rounds(blk, 1'b0, NR, 2)));
        in_valid = 1'b1; data_in = 64'hFFFF_0000_FFFF_0000;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", data_out, d0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_ignored", busy, 0);

        @(negedge clk);
        in_valid = 1'b1; data_in = 64'h0BAD_F00D_1234_5678; decrypt = 1'b0;
        @(posedge clk); #2 in_valid = 1'b0;
        for (n = 0; n < NR + 5 && !(busy && round_idx == 4'd7); n++) @(negedge clk);
        chk("clr_reached", round_idx, 7);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_right_out", right_out, 0);
        chk("clr_round_idx", round_idx, 0);
        n = 0;
        repeat (NR + 4) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("clr_no_valid", n, 0);

        @(negedge clk);
        in_valid = 1'b1; data_in = 64'h5555_AAAA_5555_AAAA;
        @(posedge clk); #2 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_pre_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_in_ready", in_ready, 1);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_data_out", data_out, 0);
        chk("rst_async_right_out", right_out, 0);
        #1 rst = 1'b0;
        n = 0;
        repeat (NR + 4) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("rst_no_valid", n, 0);

        @(negedge clk);
        in_valid = 1'b1; data_in = 64'h0F0F_0F0F_F0F0_F0F0; decrypt = 1'b0; out_ready = 1'b1;
        @(posedge clk); #2 data_in = 64'h1234_5678_9ABC_DEF0;
        wait_valid("b2b_a_valid");
        res_a = data_out;
        chk("b2b_a", res_a, swap(run_rounds(64'h0F0F_0F0F_F0F0_F0F0, 1'b0, NR, 2)));
        @(negedge clk);
        chk("b2b_ready_back", in_ready, 1);
        @(posedge clk); #2 in_valid = 1'b0;
        wait_valid("b2b_b_valid");
        res_b = data_out;
        chk("b2b_b", res_b, swap(run_rounds(64'h1234_5678_9ABC_DEF0, 1'b0, NR, 2)));

        @(negedge clk);
        in_valid3 = 1'b1; data_in3 = 64'h0000_0000_1234_5678; out_ready3 = 1'b1;
        @(posedge clk); #2 in_valid3 = 1'b0;
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid3) break;
            @(posedge clk);
            n++;
        end
        chk("r3_valid", out_valid3, 1);
        chk("r3_data", data_out3, 64'h0000_0000_EDCB_A987);
        chk("r3_latency", n, 4);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
